// File: rtl/flappy_pkg.sv
// Shared types and dimensions for the flappy game pipeline: game FSM state,
// screen size, default sprite/bar geometry and a saturating score adder.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DEAD = 2'd2
  } game_state_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam int DEF_BIRD_X    = 160;
  localparam int DEF_BIRD_W    = 24;
  localparam int DEF_BIRD_H    = 24;
  localparam int DEF_BAR_W     = 40;
  localparam int DEF_GAP_HALF  = 60;
  localparam int DEF_Y_FLOOR   = SCREEN_H;
  localparam int DEF_SCORE_MAX = 999;

  // Adds at most two bars' worth of passes and clamps instead of wrapping.
  function automatic logic [9:0] sat_add(input logic [9:0] a,
                                         input logic [1:0] b,
                                         input logic [9:0] max_v);
    logic [10:0] sum;
    sum = {1'b0, a} + {9'b0, b};
    if (sum > {1'b0, max_v}) return max_v;
    return sum[9:0];
  endfunction

endpackage

// File: rtl/bar_hit_check.sv
// Per-bar collision and pass detection. Owns the sticky "passed" flag so each
// bar scores exactly once between wraps.
module bar_hit_check
  import flappy_pkg::*;
#(
  parameter int BIRD_X   = DEF_BIRD_X,
  parameter int BIRD_W   = DEF_BIRD_W,
  parameter int BIRD_H   = DEF_BIRD_H,
  parameter int BAR_W    = DEF_BAR_W,
  parameter int GAP_HALF = DEF_GAP_HALF
) (
  input  logic       clk_25MHz,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [8:0] bird_y,
  input  logic [9:0] x_bar,
  input  logic [8:0] y_gap,
  input  logic       wraps,
  output logic       hit,
  output logic       pass_pulse
);

  logic        passed_q, passed_d;
  logic [10:0] bar_right, bird_right, bird_bottom, gap_top, gap_bottom;
  logic        x_overlap, y_outside;

  // gap_top cannot underflow: the bar generator clamps y_gap to >= 120.
  always_comb begin
    bar_right   = {1'b0, x_bar} + 11'(BAR_W);
    bird_right  = 11'(BIRD_X + BIRD_W);
    bird_bottom = {2'b0, bird_y} + 11'(BIRD_H);
    gap_top     = {2'b0, y_gap} - 11'(GAP_HALF);
    gap_bottom  = {2'b0, y_gap} + 11'(GAP_HALF);

    x_overlap  = (11'(BIRD_X) < bar_right) && ({1'b0, x_bar} < bird_right);
    y_outside  = ({2'b0, bird_y} < gap_top) || (bird_bottom > gap_bottom);
    hit        = x_overlap && y_outside;
    pass_pulse = enable && (bar_right < 11'(BIRD_X)) && !passed_q && !wraps;

    passed_d = passed_q;
    if (wraps) begin
      passed_d = 1'b0;
    end else if (pass_pulse) begin
      passed_d = 1'b1;
    end
  end

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      passed_q <= 1'b0;
    end else begin
      passed_q <= passed_d;
    end
  end

endmodule

// File: rtl/collision_score.sv
// Game FSM (idle/play/dead), collision detection and saturating score.
// Optional session high score enabled by defining COLLISION_HIGH_SCORE_EN.
module collision_score
  import flappy_pkg::*;
#(
  parameter int BIRD_X    = DEF_BIRD_X,
  parameter int BIRD_W    = DEF_BIRD_W,
  parameter int BIRD_H    = DEF_BIRD_H,
  parameter int BAR_W     = DEF_BAR_W,
  parameter int GAP_HALF  = DEF_GAP_HALF,
  parameter int Y_FLOOR   = DEF_Y_FLOOR,
  parameter int SCORE_MAX = DEF_SCORE_MAX
) (
  input  logic       clk_25MHz,
  input  logic       reset_n,
  input  logic       game_start,
  input  logic       restart,
  input  logic [8:0] bird_y,
  input  logic [9:0] x_bar0,
  input  logic [9:0] x_bar1,
  input  logic [8:0] y_gap0,
  input  logic [8:0] y_gap1,
  input  logic       wraps0,
  input  logic       wraps1,
  output logic       lose,
  output logic [9:0] score,
  output logic [9:0] best_score,
  output logic [1:0] state_o
);

  game_state_t state_q, state_d;
  logic [9:0]  score_q, score_d;
  logic        lose_q, lose_d;
  logic        in_play, hit0, hit1, pass0, pass1, floor_hit, any_hit;
  logic [10:0] bird_bottom;

  assign in_play = (state_q == PLAY);

  bar_hit_check #(
    .BIRD_X(BIRD_X), .BIRD_W(BIRD_W), .BIRD_H(BIRD_H),
    .BAR_W(BAR_W), .GAP_HALF(GAP_HALF)
  ) u_bar0 (
    .clk_25MHz (clk_25MHz),
    .reset_n   (reset_n),
    .enable    (in_play),
    .bird_y    (bird_y),
    .x_bar     (x_bar0),
    .y_gap     (y_gap0),
    .wraps     (wraps0),
    .hit       (hit0),
    .pass_pulse(pass0)
  );

  bar_hit_check #(
    .BIRD_X(BIRD_X), .BIRD_W(BIRD_W), .BIRD_H(BIRD_H),
    .BAR_W(BAR_W), .GAP_HALF(GAP_HALF)
  ) u_bar1 (
    .clk_25MHz (clk_25MHz),
    .reset_n   (reset_n),
    .enable    (in_play),
    .bird_y    (bird_y),
    .x_bar     (x_bar1),
    .y_gap     (y_gap1),
    .wraps     (wraps1),
    .hit       (hit1),
    .pass_pulse(pass1)
  );

  assign bird_bottom = {2'b0, bird_y} + 11'(BIRD_H);
  assign floor_hit   = (bird_bottom >= 11'(Y_FLOOR));
  assign any_hit     = hit0 || hit1 || floor_hit;

  // A hit outranks both a pass and a dropped game_start in the same cycle.
  always_comb begin
    state_d = state_q;
    score_d = score_q;
    lose_d  = lose_q;
    case (state_q)
      IDLE: begin
        score_d = '0;
        lose_d  = 1'b0;
        if (game_start) state_d = PLAY;
      end
      PLAY: begin
        if (any_hit) begin
          state_d = DEAD;
          lose_d  = 1'b1;
        end else if (!game_start) begin
          state_d = IDLE;
          score_d = '0;
          lose_d  = 1'b0;
        end else begin
          score_d = sat_add(score_q, {1'b0, pass0} + {1'b0, pass1}, 10'(SCORE_MAX));
        end
      end
      DEAD: begin
        lose_d = 1'b1;
        if (restart) begin
          state_d = IDLE;
          score_d = '0;
          lose_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        score_d = '0;
        lose_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      score_q <= '0;
      lose_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      lose_q  <= lose_d;
    end
  end

`ifdef COLLISION_HIGH_SCORE_EN
  logic [9:0] best_q, best_d;

  // Score is frozen on the dying edge, so score_q is the final score.
  always_comb begin
    best_d = best_q;
    if (in_play && (state_d == DEAD) && (score_q > best_q)) best_d = score_q;
  end

  always_ff @(posedge clk_25MHz or negedge reset_n) begin
    if (!reset_n) begin
      best_q <= '0;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_score = best_q;
`else
  assign best_score = '0;
`endif

  assign lose    = lose_q;
  assign score   = score_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_collision_score.sv
// Self-checking bench for collision_score: directed scenarios then random play,
// all checked against a rule-level game model.
module tb_collision_score;

  logic       clk_25MHz = 1'b0;
  logic       reset_n   = 1'b0;
  logic       game_start = 1'b0;
  logic       restart   = 1'b0;
  logic [8:0] bird_y    = 9'd228;
  logic [9:0] x_bar0    = 10'd600;
  logic [9:0] x_bar1    = 10'd900;
  logic [8:0] y_gap0    = 9'd240;
  logic [8:0] y_gap1    = 9'd240;
  logic       wraps0    = 1'b0;
  logic       wraps1    = 1'b0;
  logic       lose;
  logic [9:0] score;
  logic [9:0] best_score;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_fails  = 0;

  int m_state, m_score, m_lose, m_best;
  bit m_passed[2];

  always #20 clk_25MHz = ~clk_25MHz;

  collision_score dut (
    .clk_25MHz (clk_25MHz),
    .reset_n   (reset_n),
    .game_start(game_start),
    .restart   (restart),
    .bird_y    (bird_y),
    .x_bar0    (x_bar0),
    .x_bar1    (x_bar1),
    .y_gap0    (y_gap0),
    .y_gap1    (y_gap1),
    .wraps0    (wraps0),
    .wraps1    (wraps1),
    .lose      (lose),
    .score     (score),
    .best_score(best_score),
    .state_o   (state_o)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " state"}, {14'b0, state_o}, 16'(m_state));
    check({tag, " score"}, {6'b0, score}, 16'(m_score));
    check({tag, " lose"}, {15'b0, lose}, 16'(m_lose));
    check({tag, " best"}, {6'b0, best_score}, 16'(m_best));
  endtask

  task automatic model_reset();
    m_state = 0; m_score = 0; m_lose = 0; m_best = 0;
    m_passed[0] = 0; m_passed[1] = 0;
  endtask

  function automatic bit bar_hit(input int x, input int yg, input int by);
    bit overlap, outside;
    overlap = (160 < x + 40) && (x < 160 + 24);
    outside = (by < yg - 60) || (by + 24 > yg + 60);
    return overlap && outside;
  endfunction

  // Next-state of the game from the currently driven inputs.
  task automatic model_step();
    int xs[2];
    bit ws[2];
    int passes;
    bit hit;
    xs[0] = int'(x_bar0); xs[1] = int'(x_bar1);
    ws[0] = wraps0;       ws[1] = wraps1;
    passes = 0;
    hit = bar_hit(xs[0], int'(y_gap0), int'(bird_y)) ||
          bar_hit(xs[1], int'(y_gap1), int'(bird_y)) ||
          (int'(bird_y) + 24 >= 480);
    for (int i = 0; i < 2; i++) begin
      if (m_state == 1 && xs[i] + 40 < 160 && !m_passed[i] && !ws[i]) begin
        passes++;
        m_passed[i] = 1;
      end
      if (ws[i]) m_passed[i] = 0;
    end
    case (m_state)
      0: begin
        m_score = 0; m_lose = 0;
        if (game_start) m_state = 1;
      end
      1: begin
        if (hit) begin
`ifdef COLLISION_HIGH_SCORE_EN
          if (m_score > m_best) m_best = m_score;
`endif
          m_state = 2; m_lose = 1;
        end else if (!game_start) begin
          m_state = 0; m_score = 0; m_lose = 0;
        end else begin
          m_score = (m_score + passes > 999) ? 999 : m_score + passes;
        end
      end
      default: begin
        if (restart) begin
          m_state = 0; m_score = 0; m_lose = 0;
        end
      end
    endcase
  endtask

  task automatic clock_step(input string tag);
    model_step();
    @(posedge clk_25MHz);
    #1;
    check_all(tag);
  endtask

  task automatic pass_bar0_once(input string tag);
    x_bar0 = 10'd0;
    clock_step(tag);
    wraps0 = 1'b1; x_bar0 = 10'd600;
    clock_step(tag);
    wraps0 = 1'b0;
  endtask

  initial begin
    model_reset();
    #5;
    check_all("reset");
    @(posedge clk_25MHz); #1;
    reset_n = 1'b1;
    game_start = 1'b1;
    clock_step("idle_to_play");

    // Bird sits inside bar0's gap while the bar sweeps past it.
    for (int x = 300; x >= 0; x -= 4) begin
      x_bar0 = 10'(x);
      clock_step("sweep");
      if (x == 120) check("sweep_before_pass", {6'b0, score}, 16'd0);
      if (x == 116) check("sweep_after_pass", {6'b0, score}, 16'd1);
    end
    check("sweep_no_lose", {15'b0, lose}, 16'd0);

    wraps0 = 1'b1; x_bar0 = 10'd600;
    clock_step("wrap0");
    wraps0 = 1'b0;

    bird_y = 9'd100; x_bar0 = 10'd150;
    clock_step("bar_hit");
    check("bar_hit_lose", {15'b0, lose}, 16'd1);
    check("bar_hit_state", {14'b0, state_o}, 16'd2);
    x_bar0 = 10'd0;
    for (int i = 0; i < 3; i++) clock_step("dead_frozen");
    check("dead_score_frozen", {6'b0, score}, 16'd1);

    restart = 1'b1;
    clock_step("restart1");
    restart = 1'b0;
    check("restart1_state", {14'b0, state_o}, 16'd0);

    bird_y = 9'd456; x_bar0 = 10'd600; x_bar1 = 10'd900;
    clock_step("floor_enter_play");
    clock_step("floor_hit");
    check("floor_lose", {15'b0, lose}, 16'd1);

    restart = 1'b1; bird_y = 9'd228;
    clock_step("restart2");
    restart = 1'b0;
    clock_step("seven_enter_play");
    for (int i = 0; i < 7; i++) pass_bar0_once("seven_pass");
    check("seven_score", {6'b0, score}, 16'd7);
    bird_y = 9'd100; x_bar0 = 10'd150;
    clock_step("seven_hit");
    restart = 1'b1;
    clock_step("seven_restart");
    restart = 1'b0;
    check("seven_restart_score", {6'b0, score}, 16'd0);
    check("seven_restart_lose", {15'b0, lose}, 16'd0);
`ifdef COLLISION_HIGH_SCORE_EN
    check("seven_best", {6'b0, best_score}, 16'd7);
`else
    check("seven_best", {6'b0, best_score}, 16'd0);
`endif

    bird_y = 9'd228; x_bar0 = 10'd600;
    clock_step("sat_enter_play");
    for (int i = 0; i < 499; i++) begin
      x_bar0 = 10'd0; x_bar1 = 10'd0;
      clock_step("sat_pass");
      wraps0 = 1'b1; wraps1 = 1'b1; x_bar0 = 10'd600; x_bar1 = 10'd900;
      clock_step("sat_wrap");
      wraps0 = 1'b0; wraps1 = 1'b0;
    end
    check("sat_998", {6'b0, score}, 16'd998);
    x_bar0 = 10'd0; x_bar1 = 10'd0;
    clock_step("sat_double");
    check("sat_999", {6'b0, score}, 16'd999);
    wraps0 = 1'b1; wraps1 = 1'b1; x_bar0 = 10'd600; x_bar1 = 10'd900;
    clock_step("sat_wrap2");
    wraps0 = 1'b0; wraps1 = 1'b0; x_bar0 = 10'd0; x_bar1 = 10'd0;
    clock_step("sat_hold");
    check("sat_hold_999", {6'b0, score}, 16'd999);

    wraps0 = 1'b1; wraps1 = 1'b1; x_bar0 = 10'd600; x_bar1 = 10'd900;
    game_start = 1'b0;
    clock_step("drop_to_idle");
    wraps0 = 1'b0; wraps1 = 1'b0; game_start = 1'b1;
    clock_step("reenter_play");
    for (int i = 0; i < 3; i++) pass_bar0_once("three_pass");
    check("three_score", {6'b0, score}, 16'd3);

    // Asynchronous reset: outputs must clear between clock edges.
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk_25MHz); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      game_start = ($urandom_range(0, 19) != 0);
      restart    = ($urandom_range(0, 7) == 0);
      bird_y     = ($urandom_range(0, 9) < 7) ? 9'($urandom_range(150, 300))
                                              : 9'($urandom_range(0, 511));
      x_bar0     = 10'($urandom_range(0, 700));
      x_bar1     = 10'($urandom_range(0, 700));
      y_gap0     = 9'($urandom_range(120, 360));
      y_gap1     = 9'($urandom_range(120, 360));
      wraps0     = ($urandom_range(0, 9) == 0);
      wraps1     = ($urandom_range(0, 9) == 0);
      clock_step("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/collision_score.md
# collision_score

Downstream stage of the bar generator. Consumes both bars' `x_bar`/`y_gap`/`wraps` and the bird's vertical position. Detects bird-vs-bar and bird-vs-floor collisions, counts bars passed, and produces the `lose` flag and 10-bit `score` that feed back into the bar generators' speed and freeze logic. Holds a three-state game FSM: idle, play, dead.

## Interface
- `BIRD_X`, 160: fixed left x of bird sprite (pixels)
- `BIRD_W`, 24: bird width
- `BIRD_H`, 24: bird height
- `BAR_W`, 40: bar column width
- `GAP_HALF`, 60: half height of bar gap around `y_gap`
- `Y_FLOOR`, 480: floor line; touching it is a collision
- `SCORE_MAX`, 999: score saturation value
- `clk_25MHz` in 1: system clock
- `reset_n` in 1: asynchronous, active-low reset
- `game_start` in 1: level; play enabled while high
- `restart` in 1: single-cycle pulse; leaves dead state
- `bird_y` in 9: top y of bird sprite
- `x_bar0`, `x_bar1` in 10: left x of each bar
- `y_gap0`, `y_gap1` in 9: gap centre of each bar (120..360)
- `wraps0`, `wraps1` in 1: bar reloaded to right edge
- `lose` out 1: collision latched
- `score` out 10: bars passed, saturating
- `best_score` out 10: session high score (see Configuration)
- `state_o` out 2: FSM state for debug/display

## Operation
- FSM states:
  - IDLE (0)
    - `score`=0, `lose`=0
    - go to PLAY when `game_start`=1
  - PLAY (1)
    - evaluates hits and passes every cycle
    - go to DEAD on any hit
    - go to IDLE if `game_start` drops
  - DEAD (2)
    - `lose`=1, `score` frozen
    - go to IDLE on `restart`; `score` and `lose` cleared on that edge
- Bar hit i: x overlap AND y outside gap.
  - x overlap: `BIRD_X < x_bar_i+BAR_W` and `x_bar_i < BIRD_X+BIRD_W`
  - y outside gap: `bird_y < y_gap_i-GAP_HALF` or `bird_y+BIRD_H > y_gap_i+GAP_HALF`
- Floor hit: `bird_y+BIRD_H >= Y_FLOOR`.
- Width rules:
  - all sums computed 11-bit unsigned
  - `y_gap_i-GAP_HALF` computed 11-bit; upstream clamp guarantees it is non-negative
- Pass detection, per bar:
  - sticky `passed_i` flag
  - when `x_bar_i+BAR_W < BIRD_X` and `!passed_i`: score +1, set `passed_i`
  - `wraps_i`=1 clears `passed_i`; clear has priority over set in the same cycle
- Both bars passing in one cycle: score +2.
- Score saturates at `SCORE_MAX` and never wraps.
- Hit and pass in the same cycle: hit wins; no increment in that cycle.
- `restart` outside DEAD is ignored. `restart` and `game_start` high together in DEAD: go to IDLE first; PLAY follows on the next cycle.

## Timing
- Reset values: `lose`=0, `score`=0, `best_score`=0, `state_o`=IDLE, all `passed_i`=0.
- Inputs are used unregistered. Outputs are registered: `lose`, `score` and state update on the clock edge after the qualifying inputs are present (1-cycle latency).
- `reset_n` low mid-game returns every output to its reset value immediately, asynchronously.

## Configuration
- `COLLISION_HIGH_SCORE_EN` defined:
  - `best_score` register updates to `score` on entry to DEAD when `score > best_score`
  - survives `restart`; cleared only by `reset_n`
- Not defined: `best_score` tied to 0; no register inferred.

## Structure
- Shared package `flappy_pkg`:
  - `game_state_t` enum (IDLE/PLAY/DEAD, 2-bit)
  - screen constants (640, 480)
  - default sprite/bar dimensions
- Sub-module `bar_hit_check`, instantiated once per bar:
  - combinational overlap, gap test and pass condition
  - owns the `passed_i` flop
  - outputs `hit` and `pass_pulse`

## Test plan
- Reset, `game_start`=1, `bird_y`=228, bar0 `y_gap`=240 sweeping x 300→0 → no `lose`; `score` 0→1 the cycle after `x_bar0+40 < 160`.
- `bird_y`=100, `y_gap0`=240, `x_bar0`=150 → `lose`=1 one cycle later; `state_o`=DEAD; score frozen.
- `bird_y`=456 with no bars overlapping → floor hit, `lose`=1.
- Both bars satisfy pass in the same cycle from `score`=998 → `score`=999 (saturated), not 1000.
- DEAD with `score`=7, pulse `restart` → IDLE, `score`=0, `lose`=0; with `COLLISION_HIGH_SCORE_EN` defined, `best_score`=7.
- `reset_n` low during PLAY with `score`=3 → all outputs 0, IDLE, without waiting for a clock edge.
